// File: rtl/instr_stream_loader.sv
// Packs a WASM function-body byte stream little-endian into instruction memory write windows.
// Optional WASM_HEADER_CHECK_EN strips and validates the 8-byte module header.
module instr_stream_loader #(
   parameter int WR_BYTES      = 4,
   parameter int LOG_WR_BYTES  = 2,
   parameter int FLUSH_TIMEOUT = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [7:0]              i_byte,
   input  logic                    i_byte_vld,
   input  logic                    i_byte_last,
   output logic                    o_byte_rdy,
   output logic                    o_we,
   output logic [8*WR_BYTES-1:0]   o_wr_data,
   output logic [LOG_WR_BYTES-1:0] o_write_pointer_shift_minusone,
   input  logic                    i_wr_rdy,
   output logic                    o_load_done,
   output logic                    o_load_error,
   output logic [31:0]             o_byte_count
);

   localparam int DW = 8 * WR_BYTES;
   localparam int FW = LOG_WR_BYTES + 1;
   localparam int IW = $clog2(FLUSH_TIMEOUT + 2);

   typedef enum logic [1:0] {
      S_FILL,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_e;

   state_e                  state_q, state_d;
   logic                    rdy_q, rdy_d;
   logic                    we_q, we_d;
   logic [DW-1:0]           wr_data_q, wr_data_d;
   logic [LOG_WR_BYTES-1:0] shift_q, shift_d;
   logic                    done_q, done_d;
   logic [31:0]             count_q, count_d;
   logic [FW-1:0]           fill_cnt_q, fill_cnt_d;
   logic [IW-1:0]           idle_q, idle_d;
   logic                    last_pend_q, last_pend_d;
`ifdef WASM_HEADER_CHECK_EN
   logic [3:0]              hdr_cnt_q, hdr_cnt_d;
   logic                    err_q, err_d;

   function automatic logic [7:0] hdr_byte(input logic [2:0] idx);
      case (idx)
         3'd1:    hdr_byte = 8'h61;
         3'd2:    hdr_byte = 8'h73;
         3'd3:    hdr_byte = 8'h6D;
         3'd4:    hdr_byte = 8'h01;
         default: hdr_byte = 8'h00;
      endcase
   endfunction
`endif

   logic accept;
   logic full;
   logic tmo;

   assign accept = i_byte_vld & rdy_q;
   assign full   = (fill_cnt_q == FW'(WR_BYTES - 1));
   // Only a partial window can time out; an empty one has nothing to flush.
   assign tmo    = (FLUSH_TIMEOUT != 0) && (fill_cnt_q != '0) &&
                   (32'(idle_q) == 32'(FLUSH_TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      rdy_d       = rdy_q;
      we_d        = we_q;
      wr_data_d   = wr_data_q;
      shift_d     = shift_q;
      done_d      = done_q;
      count_d     = count_q;
      fill_cnt_d  = fill_cnt_q;
      idle_d      = idle_q;
      last_pend_d = last_pend_q;
`ifdef WASM_HEADER_CHECK_EN
      hdr_cnt_d   = hdr_cnt_q;
      err_d       = err_q;
`endif
      unique case (state_q)
         S_FILL: begin
            rdy_d = 1'b1;
            if (accept) begin
               idle_d = '0;
`ifdef WASM_HEADER_CHECK_EN
               if (!hdr_cnt_q[3]) begin
                  if (i_byte != hdr_byte(hdr_cnt_q[2:0]) || i_byte_last) begin
                     state_d = S_ERR;
                     rdy_d   = 1'b0;
                     err_d   = 1'b1;
                  end else begin
                     hdr_cnt_d = hdr_cnt_q + 1'b1;
                  end
               end else
`endif
               begin
                  wr_data_d[8*fill_cnt_q[LOG_WR_BYTES-1:0] +: 8] = i_byte;
                  fill_cnt_d  = fill_cnt_q + 1'b1;
                  last_pend_d = last_pend_q | i_byte_last;
                  if (full || i_byte_last) begin
                     state_d = S_WRITE;
                     we_d    = 1'b1;
                     rdy_d   = 1'b0;
                     shift_d = LOG_WR_BYTES'(fill_cnt_q);
                  end
               end
            end else if (tmo) begin
               state_d = S_WRITE;
               we_d    = 1'b1;
               rdy_d   = 1'b0;
               idle_d  = '0;
               shift_d = LOG_WR_BYTES'(fill_cnt_q - 1'b1);
            end else if (fill_cnt_q != '0) begin
               idle_d = idle_q + 1'b1;
            end
         end
         S_WRITE: begin
            rdy_d = 1'b0;
            if (i_wr_rdy) begin
               count_d    = count_q + 32'(fill_cnt_q);
               fill_cnt_d = '0;
               we_d       = 1'b0;
               wr_data_d  = '0;
               shift_d    = '0;
               if (last_pend_q) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_FILL;
                  rdy_d   = 1'b1;
               end
            end
         end
         S_DONE: rdy_d = 1'b0;
         S_ERR:  rdy_d = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_FILL;
         rdy_q       <= 1'b0;
         we_q        <= 1'b0;
         wr_data_q   <= '0;
         shift_q     <= '0;
         done_q      <= 1'b0;
         count_q     <= '0;
         fill_cnt_q  <= '0;
         idle_q      <= '0;
         last_pend_q <= 1'b0;
`ifdef WASM_HEADER_CHECK_EN
         hdr_cnt_q   <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         rdy_q       <= rdy_d;
         we_q        <= we_d;
         wr_data_q   <= wr_data_d;
         shift_q     <= shift_d;
         done_q      <= done_d;
         count_q     <= count_d;
         fill_cnt_q  <= fill_cnt_d;
         idle_q      <= idle_d;
         last_pend_q <= last_pend_d;
`ifdef WASM_HEADER_CHECK_EN
         hdr_cnt_q   <= hdr_cnt_d;
         err_q       <= err_d;
`endif
      end
   end

   assign o_byte_rdy                     = rdy_q;
   assign o_we                           = we_q;
   assign o_wr_data                      = wr_data_q;
   assign o_write_pointer_shift_minusone = shift_q;
   assign o_load_done                    = done_q;
   assign o_byte_count                   = count_q;
`ifdef WASM_HEADER_CHECK_EN
   assign o_load_error                   = err_q;
`else
   assign o_load_error                   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_stream_loader.sv
// Scoreboard bench for instr_stream_loader: stimulus queues expected writes,
// a negedge monitor pops and compares each transferred window.
module tb_instr_stream_loader;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic [7:0]  i_byte = 8'h00;
   logic        i_byte_vld = 1'b0;
   logic        i_byte_last = 1'b0;
   logic        o_byte_rdy;
   logic        o_we;
   logic [31:0] o_wr_data;
   logic [1:0]  o_write_pointer_shift_minusone;
   logic        i_wr_rdy = 1'b1;
   logic        o_load_done;
   logic        o_load_error;
   logic [31:0] o_byte_count;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  s;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   instr_stream_loader dut (
      .i_clk                          (i_clk),
      .i_rst                          (i_rst),
      .i_byte                         (i_byte),
      .i_byte_vld                     (i_byte_vld),
      .i_byte_last                    (i_byte_last),
      .o_byte_rdy                     (o_byte_rdy),
      .o_we                           (o_we),
      .o_wr_data                      (o_wr_data),
      .o_write_pointer_shift_minusone (o_write_pointer_shift_minusone),
      .i_wr_rdy                       (i_wr_rdy),
      .o_load_done                    (o_load_done),
      .o_load_error                   (o_load_error),
      .o_byte_count                   (o_byte_count)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   always @(negedge i_clk) begin
      if (!i_rst && o_we && i_wr_rdy) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got data %h with no expected write", o_wr_data);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wr_data", o_wr_data, e.d);
            chk("shift", 32'(o_write_pointer_shift_minusone), 32'(e.s));
         end
      end
   end

   task automatic push(input logic [31:0] d, input logic [1:0] s);
      exp_t e;
      e.d = d;
      e.s = s;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge i_clk);
         #1;
      end
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_byte_vld = 1'b0;
      i_byte_last = 1'b0;
      tick(1);
      chk("rst_rdy", 32'(o_byte_rdy), 0);
      chk("rst_we", 32'(o_we), 0);
      chk("rst_data", o_wr_data, 0);
      chk("rst_shift", 32'(o_write_pointer_shift_minusone), 0);
      chk("rst_done", 32'(o_load_done), 0);
      chk("rst_err", 32'(o_load_error), 0);
      chk("rst_count", o_byte_count, 0);
      i_rst = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic last);
      int n = 0;
      i_byte = b;
      i_byte_last = last;
      i_byte_vld = 1'b1;
      while (!o_byte_rdy && n < 50) begin
         tick(1);
         n++;
      end
      if (n >= 50) chk("send_timeout", 0, 1);
      tick(1);
      i_byte_vld = 1'b0;
      i_byte_last = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!o_load_done && n < 60) begin
         tick(1);
         n++;
      end
      chk("done", 32'(o_load_done), 1);
   endtask

   task automatic full_window();
      push(32'h00200B41, 2'd3);
      send(8'h41, 1'b0);
      send(8'h0B, 1'b0);
      send(8'h20, 1'b0);
      send(8'h00, 1'b1);
      chk("full_we_latency", 32'(o_we), 1);
      tick(1);
      chk("full_we_drop", 32'(o_we), 0);
      wait_done();
      chk("full_count", o_byte_count, 4);
      chk("full_rdy", 32'(o_byte_rdy), 0);
   endtask

   initial begin
      do_reset();
`ifdef WASM_HEADER_CHECK_EN
      push(32'h0000000B, 2'd0);
      send(8'h00, 1'b0);
      send(8'h61, 1'b0);
      send(8'h73, 1'b0);
      send(8'h6D, 1'b0);
      send(8'h01, 1'b0);
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      send(8'h00, 1'b0);
      chk("hdr_no_we", 32'(o_we), 0);
      send(8'h0B, 1'b1);
      wait_done();
      chk("hdr_count", o_byte_count, 1);
      chk("hdr_err", 32'(o_load_error), 0);

      do_reset();
      send(8'h00, 1'b0);
      send(8'h61, 1'b0);
      send(8'h73, 1'b0);
      send(8'h6E, 1'b0);
      chk("bad_err", 32'(o_load_error), 1);
      chk("bad_rdy", 32'(o_byte_rdy), 0);
      tick(10);
      chk("bad_we", 32'(o_we), 0);
      chk("bad_done", 32'(o_load_done), 0);
      chk("bad_count", o_byte_count, 0);
`else
      full_window();

      do_reset();
      i_byte_last = 1'b1;
      tick(4);
      i_byte_last = 1'b0;
      chk("last_novld_we", 32'(o_we), 0);
      push(32'h00000B6A, 2'd1);
      send(8'h6A, 1'b0);
      send(8'h0B, 1'b1);
      wait_done();
      chk("part_count", o_byte_count, 2);

      do_reset();
      i_wr_rdy = 1'b0;
      push(32'h44332211, 2'd3);
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      send(8'h44, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("bp_we", 32'(o_we), 1);
         chk("bp_data", o_wr_data, 32'h44332211);
         chk("bp_rdy", 32'(o_byte_rdy), 0);
         tick(1);
      end
      i_wr_rdy = 1'b1;
      tick(1);
      chk("bp_we_drop", 32'(o_we), 0);
      chk("bp_count", o_byte_count, 4);
      chk("bp_done", 32'(o_load_done), 0);
      chk("bp_rdy_back", 32'(o_byte_rdy), 1);

      do_reset();
      push(32'h00030201, 2'd2);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      tick(15);
      chk("tmo_early", 32'(o_we), 0);
      tick(1);
      chk("tmo_we", 32'(o_we), 1);
      tick(1);
      chk("tmo_count", o_byte_count, 3);
      chk("tmo_done", 32'(o_load_done), 0);
      push(32'h0000000B, 2'd0);
      send(8'h0B, 1'b1);
      wait_done();
      chk("tmo_count2", o_byte_count, 4);

      do_reset();
      push(32'h04030201, 2'd3);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      tick(15);
      send(8'h04, 1'b1);
      wait_done();
      chk("race_count", o_byte_count, 4);

      do_reset();
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b0);
      do_reset();
      tick(20);
      chk("rstmid_we", 32'(o_we), 0);
      chk("rstmid_count", o_byte_count, 0);
      full_window();
`endif
      tick(2);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_stream_loader.md
Name: instr_stream_loader

Overview:
- Producer for the instruction memory write port, which is currently tied off (we=0).
- Accepts a byte stream of a WASM function body over a valid/ready handshake.
- Packs the bytes little-endian into write windows and drives we / write_pointer_shift_minusone / wr_data into the instruction memory controller.
- Sits between the host/boot interface and the instruction memory controller, alongside the core.

Parameters:
- WR_BYTES, 4, bytes per write window; wr_data width = 8*WR_BYTES.
- LOG_WR_BYTES, 2, log2(WR_BYTES); width of the shift field.
- FLUSH_TIMEOUT, 16, idle cycles before a partial window is flushed; 0 disables timeout flush.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_byte  in  8  stream byte
- i_byte_vld  in  1  byte valid
- i_byte_last  in  1  qualifies the final byte of the stream
- o_byte_rdy  out  1  loader can accept a byte
- o_we  out  1  write request to the instruction memory
- o_wr_data  out  8*WR_BYTES  packed window; byte k at [8k+7:8k]
- o_write_pointer_shift_minusone  out  LOG_WR_BYTES  valid bytes in window minus 1
- i_wr_rdy  in  1  instruction memory has space; a write transfers when o_we & i_wr_rdy
- o_load_done  out  1  whole stream written
- o_load_error  out  1  header check failed
- o_byte_count  out  32  bytes written to instruction memory so far

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous, active-high, i_rst.
- Reset values: o_byte_rdy=0, o_we=0, o_wr_data=0, shift=0, o_load_done=0, o_load_error=0, o_byte_count=0. State=FILL from the first cycle after reset.
- Reset mid-operation discards the partial window and any pending write. No write is issued after reset until new bytes arrive.
- A byte is accepted when i_byte_vld & o_byte_rdy.
- FILL:
  - o_byte_rdy=1.
  - Accepted byte goes into lane fill_cnt; fill_cnt increments.
  - On acceptance with fill_cnt+1==WR_BYTES, or with i_byte_last=1: latch the window and go to WRITE.
  - A byte accepted with i_byte_last latches last_pending.
- Timeout flush:
  - Idle counter resets on every accepted byte.
  - If fill_cnt>0 and the counter reaches FLUSH_TIMEOUT, go to WRITE with the partial window.
  - With FLUSH_TIMEOUT=0 there is no timeout flush.
- WRITE:
  - o_byte_rdy=0, o_we=1.
  - o_wr_data and shift (=fill_cnt-1) are held stable until i_wr_rdy.
  - Unused upper lanes are 0.
  - On transfer: o_byte_count += fill_cnt, fill_cnt=0, o_we drops the next cycle.
  - Next state is DONE if last_pending, else FILL.
- Latency: o_we rises the cycle after the completing byte is accepted. Back-to-back sustained throughput is WR_BYTES bytes per WR_BYTES+1 cycles.
- DONE: o_load_done=1 sticky until reset; o_byte_rdy=0; input is ignored.
- ERR (only with the optional feature): o_load_error=1 sticky; o_byte_rdy=0; no writes.
- Boundaries:
  - A last byte landing in lane WR_BYTES-1 produces a single full write, not an extra empty write.
  - Timeout and acceptance in the same cycle: acceptance wins and the counter clears.
  - i_byte_last with i_byte_vld=0 has no effect.
  - o_byte_count wraps modulo 2^32.

Optional Feature:
- Macro: WASM_HEADER_CHECK_EN.
- When defined:
  - The first 8 accepted bytes are compared against 00 61 73 6D 01 00 00 00 and are not written to memory.
  - On the first mismatching byte the loader enters ERR.
  - i_byte_last inside the header also enters ERR.
  - After a good header, normal FILL starts with fill_cnt=0.
- When undefined:
  - All bytes are written verbatim.
  - o_load_error is tied 0.
  - There is no header counter.

Test Plan:
- Full window: bytes 41 0B 20 00 (last on 4th), i_wr_rdy=1 -> one o_we pulse, wr_data=0x00200B41, shift=3, o_byte_count=4, o_load_done=1.
- Partial last: bytes 6A 0B (last on 2nd) -> wr_data=0x00000B6A, shift=1, count=2, done.
- Backpressure: 4 bytes, i_wr_rdy=0 for 5 cycles -> o_we held 5+ cycles with stable data, o_byte_rdy=0 throughout, single transfer when i_wr_rdy rises.
- Timeout: 3 bytes 01 02 03, then idle 16 cycles -> write wr_data=0x00030201, shift=2, no done. A following byte 0B with last -> second write, shift=0, done, count=4.
- Reset mid-fill: 2 bytes, then i_rst for 1 cycle -> no write, all outputs 0. A subsequent 4-byte stream behaves as the full-window case.
- WASM_HEADER_CHECK_EN:
  - Valid header followed by 0B (last) -> single write 0x0000000B, count=1.
  - Header with byte 3 = 6E -> o_load_error=1 after that byte, no o_we ever.
